// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, FSM encoding
// and the index-width helper.
package nsa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/rip_adder.sv
// 4-bit ripple-carry adder; the combinational stage reused every cycle by
// nibble_serial_adder.
module rip_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit ripple stage over NIBBLES cycles, LSB first.
// Optional signed-overflow output enabled by NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = idx_w(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
  logic             carry_r;
  logic [IDX_W-1:0] idx;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic             last;

  rip_adder u_rip_adder (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry_r),
    .s    (nib_sum),
    .cout (nib_cout)
  );

  // New nibble enters at the top; after NIBBLES shifts the result is aligned.
  assign res_nxt = WIDTH'({nib_sum, res_sh} >> NIBBLE_W);
  assign last    = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      carry   <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else if (state == IDLE && in_valid) begin
      a_sh    <= a;
      b_sh    <= b;
      carry_r <= c_in;
      idx     <= '0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> NIBBLE_W;
      b_sh    <= b_sh >> NIBBLE_W;
      res_sh  <= res_nxt;
      carry_r <= nib_cout;
      idx     <= idx + IDX_W'(1);
      // Outputs update only when a full result exists, so they hold in IDLE.
      if (last) begin
        sum   <= res_nxt;
        carry <= nib_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ovf   <= (a_sh[3] ^ b_sh[3] ^ nib_sum[3]) ^ nib_cout;
`endif
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed scoreboard bench for nibble_serial_adder (WIDTH=16); checks ovf
// when NIBBLE_SERIAL_ADDER_OVF_EN is defined.
module tb_nibble_serial_adder;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         c_in = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, carry, busy;
  logic [W-1:0] sum;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] full;
    exp_t r;
    full    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    r.sum   = full[W-1:0];
    r.carry = full[W];
    r.ovf   = (x[W-1] ^ y[W-1] ^ full[W-1]) ^ full[W];
    return r;
  endfunction

  // Drive one operand set and hold it through the accepting edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("send_ready", {31'd0, in_ready}, 32'd1);
    a = x; b = y; c_in = ci; in_valid = 1'b1;
    sb.push_back(model(x, y, ci));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic receive(input string tag, input bit chk_lat, output int busy_cycles);
    int   lat = 0;
    exp_t e;
    busy_cycles = busy ? 1 : 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cycles++;
    end
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    if (chk_lat) check({tag, "_latency"}, lat, W / 4);
    check({tag, "_sb_nonempty"}, (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_sum"}, {16'd0, sum}, {16'd0, e.sum});
      check({tag, "_carry"}, {31'd0, carry}, {31'd0, e.carry});
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
`endif
    end
  endtask

  task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int bc;
    send(x, y, ci);
    receive(tag, 1'b1, bc);
    @(posedge clk); #1;
    check({tag, "_idle"}, {30'd0, busy, in_ready}, 32'd1);
  endtask

  initial begin
    int   bc;
    bit   seen;
    exp_t held;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_carry", {31'd0, carry}, 32'd0);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add with latency and busy-length checks
    send(16'h1234, 16'h4321, 1'b0);
    receive("add_1234", 1'b1, bc);
    check("add_1234_busy_cycles", bc, 5);
    check("add_1234_sum_const", {16'd0, sum}, 32'h5555);
    @(posedge clk); #1;
    check("add_1234_busy_after", {31'd0, busy}, 32'd0);
    check("add_1234_sum_held", {16'd0, sum}, 32'h5555);

    op("ripple_ffff_1", 16'hFFFF, 16'h0001, 1'b0);
    check("ripple_sum_const", {15'd0, carry, sum}, 32'h1_0000);
    op("max_cin", 16'hFFFF, 16'hFFFF, 1'b1);
    op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0);
    op("neg_ovf", 16'h8000, 16'h8000, 1'b0);

    // Backpressure with new operands offered while DONE
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0);
    receive("bp", 1'b1, bc);
    a = 16'h0A0A; b = 16'h0505; c_in = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", {30'd0, out_valid, in_ready}, 32'd2);
      check("bp_hold_sum", {15'd0, carry, sum}, 32'h0_3333);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", {30'd0, in_ready, out_valid}, 32'd2);
    check("bp_release_sum_held", {16'd0, sum}, 32'h3333);
    sb.push_back(model(16'h0A0A, 16'h0505, 1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    receive("bp_new", 1'b1, bc);
    @(posedge clk); #1;

    // Asynchronous reset during the second RUN cycle
    send(16'h00F0, 16'h0010, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_sum", {15'd0, carry, sum}, 32'd0);
    held = sb.pop_front();
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("arst_no_out_valid", {31'd0, seen}, 32'd0);
    check("arst_discarded_nonzero", {16'd0, held.sum}, 32'h0100);
    op("post_rst", 16'h0001, 16'h0002, 1'b0);

    for (int i = 0; i < 3; i++)
      op("rand", W'($urandom), W'($urandom), 1'($urandom));

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
